round_referee: RTL and testbench

Sits between the game engine and the scoreboard. It turns per-frame collision flags into one-cycle round-result strobes (p1_won / p2_won / score_en), which drive the score counter's enable and clock inputs. It also sequences rounds (play, report, pause, next round) and declares the match over when a player reaches WIN_SCORE. On match restart it issues a scoreboard clear pulse.

---
 rtl/round_referee_if.sv | 30 +++
 rtl/round_referee.sv | 155 +++++++++++++++
 tb/tb_round_referee.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/round_referee_if.sv
// Signal bundle between the game engine (master) and the round referee (slave):
// per-frame inputs in, round-result strobes, tallies and match status out.
interface round_referee_if;
  logic       start;
  logic       frame_tick;
  logic       crash1;
  logic       crash2;
  logic       round_active;
  logic       p1_won;
  logic       p2_won;
  logic       draw;
  logic       score_en;
  logic       clear_scores;
  logic [3:0] tally1;
  logic [3:0] tally2;
  logic       match_over;
  logic [1:0] match_winner;

  modport master (
    output start, frame_tick, crash1, crash2,
    input  round_active, p1_won, p2_won, draw, score_en, clear_scores,
    input  tally1, tally2, match_over, match_winner
  );

  modport slave (
    input  start, frame_tick, crash1, crash2,
    output round_active, p1_won, p2_won, draw, score_en, clear_scores,
    output tally1, tally2, match_over, match_winner
  );
endinterface

// File: rtl/round_referee.sv
// Round referee: turns per-frame crash flags into registered round-result strobes and
// sequences play/report/pause/match-end. Optional macro ROUND_REFEREE_DRAW_POINT_EN awards a draw to both.
module round_referee #(
  parameter int WIN_SCORE    = 5,
  parameter int PAUSE_CYCLES = 25000000,
  parameter int PAUSE_W      = 25
) (
  input logic            clk,
  input logic            reset,
  round_referee_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    REPORT    = 3'd2,
    PAUSE     = 3'd3,
    MATCH_END = 3'd4
  } state_t;

  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [PAUSE_W-1:0] pause_cnt, pause_cnt_nxt;
  logic [3:0]         tally1_p0, tally2_p0, tally1_nxt, tally2_nxt;
  logic [1:0]         winner_p0, winner_nxt;
  logic               round_active_p0, round_active_nxt;
  logic               p1_won_p0, p1_won_nxt;
  logic               p2_won_p0, p2_won_nxt;
  logic               draw_p0, draw_nxt;
  logic               score_en_p0, score_en_nxt;
  logic               clear_p0, clear_nxt;
  logic               match_over_p0, match_over_nxt;

  // A tally never moves past WIN_SCORE, even if a stray increment slips in.
  function automatic logic [3:0] tally_inc(input logic [3:0] t);
    return (t >= WIN) ? WIN : t + 4'd1;
  endfunction

  function automatic logic [1:0] winner_of(input logic [3:0] t1, input logic [3:0] t2);
    return {t2 >= WIN, t1 >= WIN};
  endfunction

  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = '0;
    tally1_nxt    = tally1_p0;
    tally2_nxt    = tally2_p0;
    winner_nxt    = winner_p0;
    p1_won_nxt    = 1'b0;
    p2_won_nxt    = 1'b0;
    draw_nxt      = 1'b0;
    score_en_nxt  = 1'b0;
    clear_nxt     = 1'b0;

    case (state)
      IDLE, MATCH_END: begin
        if (bus.start) begin
          state_nxt  = PLAY;
          clear_nxt  = 1'b1;
          tally1_nxt = '0;
          tally2_nxt = '0;
          winner_nxt = 2'b00;
        end
      end
      PLAY: begin
        if (bus.frame_tick && (bus.crash1 || bus.crash2)) begin
          state_nxt = REPORT;
          if (bus.crash1 && bus.crash2) begin
            draw_nxt = 1'b1;
`ifdef ROUND_REFEREE_DRAW_POINT_EN
            p1_won_nxt   = 1'b1;
            p2_won_nxt   = 1'b1;
            score_en_nxt = 1'b1;
            tally1_nxt   = tally_inc(tally1_p0);
            tally2_nxt   = tally_inc(tally2_p0);
`endif
          end else if (bus.crash2) begin
            p1_won_nxt   = 1'b1;
            score_en_nxt = 1'b1;
            tally1_nxt   = tally_inc(tally1_p0);
          end else begin
            p2_won_nxt   = 1'b1;
            score_en_nxt = 1'b1;
            tally2_nxt   = tally_inc(tally2_p0);
          end
        end
      end
      REPORT: begin
        // Tallies already carry this round's point, so the win test looks at them directly.
        if (tally1_p0 >= WIN || tally2_p0 >= WIN) begin
          state_nxt  = MATCH_END;
          winner_nxt = winner_of(tally1_p0, tally2_p0);
        end else begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_cnt == PAUSE_LAST) begin
          state_nxt = PLAY;
        end else begin
          pause_cnt_nxt = pause_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    round_active_nxt = (state_nxt == PLAY);
    match_over_nxt   = (state_nxt == MATCH_END);
  end

  // Register stage: every output leaves from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pause_cnt       <= '0;
      tally1_p0       <= '0;
      tally2_p0       <= '0;
      winner_p0       <= 2'b00;
      round_active_p0 <= 1'b0;
      p1_won_p0       <= 1'b0;
      p2_won_p0       <= 1'b0;
      draw_p0         <= 1'b0;
      score_en_p0     <= 1'b0;
      clear_p0        <= 1'b0;
      match_over_p0   <= 1'b0;
    end else begin
      state           <= state_nxt;
      pause_cnt       <= pause_cnt_nxt;
      tally1_p0       <= tally1_nxt;
      tally2_p0       <= tally2_nxt;
      winner_p0       <= winner_nxt;
      round_active_p0 <= round_active_nxt;
      p1_won_p0       <= p1_won_nxt;
      p2_won_p0       <= p2_won_nxt;
      draw_p0         <= draw_nxt;
      score_en_p0     <= score_en_nxt;
      clear_p0        <= clear_nxt;
      match_over_p0   <= match_over_nxt;
    end
  end

  assign bus.round_active = round_active_p0;
  assign bus.p1_won       = p1_won_p0;
  assign bus.p2_won       = p2_won_p0;
  assign bus.draw         = draw_p0;
  assign bus.score_en     = score_en_p0;
  assign bus.clear_scores = clear_p0;
  assign bus.tally1       = tally1_p0;
  assign bus.tally2       = tally2_p0;
  assign bus.match_over   = match_over_p0;
  assign bus.match_winner = winner_p0;

endmodule

// File: tb/tb_round_referee.sv
// Bench for round_referee: directed match scenarios followed by random frames, all
// compared each cycle against a countdown-style model of the round timeline.
module tb_round_referee;
  localparam int WIN   = 3;
  localparam int PAUSE = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  round_referee_if bus ();

  round_referee #(
    .WIN_SCORE   (WIN),
    .PAUSE_CYCLES(PAUSE),
    .PAUSE_W     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a match is idle, live, frozen (counting down to resumption) or over.
  bit m_idle, m_ended, m_active, m_end_next;
  int m_resume;
  int m_t1, m_t2, m_winner;
  bit m_p1, m_p2, m_draw, m_sen, m_clr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit st, input bit tk, input bit c1, input bit c2);
    m_p1 = 0; m_p2 = 0; m_draw = 0; m_sen = 0; m_clr = 0;
    if (r) begin
      m_idle = 1; m_ended = 0; m_active = 0; m_end_next = 0; m_resume = 0;
      m_t1 = 0; m_t2 = 0; m_winner = 0;
    end else if (m_idle || m_ended) begin
      if (st) begin
        m_idle = 0; m_ended = 0; m_active = 1;
        m_t1 = 0; m_t2 = 0; m_winner = 0; m_clr = 1;
      end
    end else if (m_active) begin
      if (tk && (c1 || c2)) begin
        m_active = 0;
        if (c1 && c2) begin
          m_draw = 1;
`ifdef ROUND_REFEREE_DRAW_POINT_EN
          m_p1 = 1; m_p2 = 1; m_sen = 1; m_t1++; m_t2++;
`endif
        end else if (c2) begin
          m_p1 = 1; m_sen = 1; m_t1++;
        end else begin
          m_p2 = 1; m_sen = 1; m_t2++;
        end
        m_end_next = (m_t1 == WIN) || (m_t2 == WIN);
        m_resume   = PAUSE + 1;
      end
    end else if (m_end_next) begin
      m_end_next = 0;
      m_ended    = 1;
      m_winner   = (m_t1 == WIN ? 1 : 0) + (m_t2 == WIN ? 2 : 0);
    end else begin
      m_resume--;
      if (m_resume == 0) m_active = 1;
    end
  endtask

  task automatic step(input bit r, input bit st, input bit tk, input bit c1, input bit c2);
    reset          = r;
    bus.start      = st;
    bus.frame_tick = tk;
    bus.crash1     = c1;
    bus.crash2     = c2;
    @(posedge clk);
    model_edge(r, st, tk, c1, c2);
    @(negedge clk);
    check_eq("round_active", 32'(bus.round_active), 32'(m_active));
    check_eq("p1_won",       32'(bus.p1_won),       32'(m_p1));
    check_eq("p2_won",       32'(bus.p2_won),       32'(m_p2));
    check_eq("draw",         32'(bus.draw),         32'(m_draw));
    check_eq("score_en",     32'(bus.score_en),     32'(m_sen));
    check_eq("clear_scores", 32'(bus.clear_scores), 32'(m_clr));
    check_eq("tally1",       32'(bus.tally1),       32'(m_t1));
    check_eq("tally2",       32'(bus.tally2),       32'(m_t2));
    check_eq("match_over",   32'(bus.match_over),   32'(m_ended));
    check_eq("match_winner", 32'(bus.match_winner), 32'(m_winner));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_idle = 1; m_ended = 0; m_active = 0; m_end_next = 0; m_resume = 0;
    m_t1 = 0; m_t2 = 0; m_winner = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.crash1 = 1'b0; bus.crash2 = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1);
    idle_cycles(6);
    step(0, 0, 1, 1, 1);
    idle_cycles(6);
    for (int r = 0; r < 3; r++) begin
      step(0, 0, 1, 1, 0);
      idle_cycles(6);
    end
    step(0, 1, 0, 0, 0);
    idle_cycles(2);
    step(0, 0, 1, 0, 1);
    idle_cycles(3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
